// File: rtl/gfx_pkg.sv
// Shared graphics definitions: default video timing, counter/colour widths,
// the packed colour-word layout delivered by color_ram, and the channel
// scaling helper used by the output pipeline.
package gfx_pkg;

  // Default timing (pixel clocks and lines)
  localparam int unsigned H_TOTAL_DEF  = 456;
  localparam int unsigned H_VIS_DEF    = 336;
  localparam int unsigned HS_START_DEF = 376;
  localparam int unsigned HS_LEN_DEF   = 32;
  localparam int unsigned V_TOTAL_DEF  = 262;
  localparam int unsigned V_VIS_DEF    = 240;
  localparam int unsigned VS_START_DEF = 248;
  localparam int unsigned VS_LEN_DEF   = 3;

  // Widths
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned COLOUR_W = 16;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned CHAN_W   = 8;

  // Colour word from color_ram: [15:12] intensity, [11:8] R, [7:4] G, [3:0] B
  typedef struct packed {
    logic [NIB_W-1:0] intensity;
    logic [NIB_W-1:0] r;
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] b;
  } colour_word_t;

  // Blank and raw sync flags travelling alongside a pixel
  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
  } sync_t;

  // c * (i + 1): peaks at 15 * 16 = 240, so 8 bits never overflow
  function automatic logic [CHAN_W-1:0] scale_chan(input logic [NIB_W-1:0] c,
                                                    input logic [NIB_W-1:0] i);
    return CHAN_W'(c) * (CHAN_W'(i) + CHAN_W'(1));
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing generator: horizontal/vertical counters, blank and raw sync
// decode, and the frame_start strobe.
// Ports:
//   clk, rst_b       clock, async active-low reset
//   pix_ce           pixel clock enable; counters advance only when high
//   hcount, vcount   current raster position (registered)
//   hblank, vblank   blanking decoded combinationally from the counters
//   hsync, vsync     raw active-high sync decoded from the counters
//   frame_start      one-clock pulse after the strobe that wraps both counters
module video_timing
  import gfx_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned H_VIS    = H_VIS_DEF,
  parameter int unsigned HS_START = HS_START_DEF,
  parameter int unsigned HS_LEN   = HS_LEN_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned V_VIS    = V_VIS_DEF,
  parameter int unsigned VS_START = VS_START_DEF,
  parameter int unsigned VS_LEN   = VS_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(HS_START + HS_LEN);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(VS_START + VS_LEN);

  logic h_wrap_c;
  logic v_wrap_c;

  assign h_wrap_c = (hcount == H_LAST);
  assign v_wrap_c = (vcount == V_LAST);

  // Counters and frame_start; frame_start is a single clk wide regardless of pix_ce
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        frame_start <= h_wrap_c && v_wrap_c;
        hcount      <= h_wrap_c ? '0 : hcount + CNT_W'(1);
        if (h_wrap_c) begin
          vcount <= v_wrap_c ? '0 : vcount + CNT_W'(1);
        end
      end
    end
  end

  // Undelayed decode, consumed upstream and by the colour pipeline
  always_comb begin
    hblank = (hcount >= H_VIS_C);
    vblank = (vcount >= V_VIS_C);
    hsync  = (hcount >= HS_BEG_C) && (hcount < HS_END_C);
    vsync  = (vcount >= VS_BEG_C) && (vcount < VS_END_C);
  end

endmodule

// File: rtl/video_out.sv
// Video output stage: raster timing plus a two-stage colour pipeline that
// scales the 4-bit channels by intensity and keeps sync/de aligned with RGB.
// Ports:
//   clk, rst_b             clock, async active-low reset
//   pix_ce                 pixel clock enable (may be held high)
//   D                      colour word for the current hpos/vpos
//   hpos, vpos             current raster position, to address generation
//   hblank, vblank         undelayed blanking, to upstream stages
//   red, green, blue       scaled colour, two strobes after D
//   hsync_b, vsync_b, de   active-low syncs and display enable, aligned with RGB
//   frame_start            one-clock pulse when the raster returns to 0,0
module video_out
  import gfx_pkg::*;
#(
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned H_VIS    = H_VIS_DEF,
  parameter int unsigned HS_START = HS_START_DEF,
  parameter int unsigned HS_LEN   = HS_LEN_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned V_VIS    = V_VIS_DEF,
  parameter int unsigned VS_START = VS_START_DEF,
  parameter int unsigned VS_LEN   = VS_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                pix_ce,
  input  logic [COLOUR_W-1:0] D,
  output logic [CNT_W-1:0]    hpos,
  output logic [CNT_W-1:0]    vpos,
  output logic                hblank,
  output logic                vblank,
  output logic [CHAN_W-1:0]   red,
  output logic [CHAN_W-1:0]   green,
  output logic [CHAN_W-1:0]   blue,
  output logic                hsync_b,
  output logic                vsync_b,
  output logic                de,
  output logic                frame_start
);

  logic hsync_raw;
  logic vsync_raw;

  video_timing #(
    .H_TOTAL  (H_TOTAL),
    .H_VIS    (H_VIS),
    .HS_START (HS_START),
    .HS_LEN   (HS_LEN),
    .V_TOTAL  (V_TOTAL),
    .V_VIS    (V_VIS),
    .VS_START (VS_START),
    .VS_LEN   (VS_LEN)
  ) u_timing (
    .clk         (clk),
    .rst_b       (rst_b),
    .pix_ce      (pix_ce),
    .hcount      (hpos),
    .vcount      (vpos),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync       (hsync_raw),
    .vsync       (vsync_raw),
    .frame_start (frame_start)
  );

  colour_word_t pix_q;
  sync_t        ctl_q;

  // Stage 1: capture the colour word with the blank/sync of its raster position.
  // Blank resets high so the first strobe after reset cannot raise de.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pix_q <= '0;
      ctl_q <= '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};
    end else if (pix_ce) begin
      pix_q <= colour_word_t'(D);
      ctl_q <= '{blank: hblank | vblank, hsync: hsync_raw, vsync: vsync_raw};
    end
  end

  logic [CHAN_W-1:0] red_c;
  logic [CHAN_W-1:0] green_c;
  logic [CHAN_W-1:0] blue_c;

  // Channel scaling, forced to black in blanking
  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    if (!ctl_q.blank) begin
      red_c   = scale_chan(pix_q.r, pix_q.intensity);
      green_c = scale_chan(pix_q.g, pix_q.intensity);
      blue_c  = scale_chan(pix_q.b, pix_q.intensity);
    end
  end

  // Stage 2: registered outputs; syncs take the same path as RGB
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      de      <= 1'b0;
      hsync_b <= 1'b1;
      vsync_b <= 1'b1;
    end else if (pix_ce) begin
      red     <= red_c;
      green   <= green_c;
      blue    <= blue_c;
      de      <= ~ctl_q.blank;
      hsync_b <= ~ctl_q.hsync;
      vsync_b <= ~ctl_q.vsync;
    end
  end

endmodule

// File: tb/tb_video_out.sv
// Self-checking bench for video_out: a default-timing instance for pixel,
// blanking, sync and strobe-rate behaviour, and a small-timing instance for
// whole-frame counts and mid-frame reset.
module tb_video_out;

  localparam int HT = 456, HV = 336, HSS = 376, HSL = 32;
  localparam int VT = 262, VV = 240, VSS = 248, VSL = 3;

  localparam int SHT = 24, SHV = 16, SHSS = 18, SHSL = 3;
  localparam int SVT = 10, SVV = 7,  SVSS = 8,  SVSL = 2;
  localparam int SF  = SHT * SVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance
  logic        rst_b, pix_ce;
  logic [15:0] d;
  logic [8:0]  hpos, vpos;
  logic        hblank, vblank, hsync_b, vsync_b, de, frame_start;
  logic [7:0]  red, green, blue;

  video_out dut (
    .clk(clk), .rst_b(rst_b), .pix_ce(pix_ce), .D(d),
    .hpos(hpos), .vpos(vpos), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue),
    .hsync_b(hsync_b), .vsync_b(vsync_b), .de(de), .frame_start(frame_start)
  );

  // Small-timing instance
  logic        s_rst_b, s_pix_ce;
  logic [15:0] s_d;
  logic [8:0]  s_hpos, s_vpos;
  logic        s_hblank, s_vblank, s_hsync_b, s_vsync_b, s_de, s_frame_start;
  logic [7:0]  s_red, s_green, s_blue;

  video_out #(
    .H_TOTAL(SHT), .H_VIS(SHV), .HS_START(SHSS), .HS_LEN(SHSL),
    .V_TOTAL(SVT), .V_VIS(SVV), .VS_START(SVSS), .VS_LEN(SVSL)
  ) dut_s (
    .clk(clk), .rst_b(s_rst_b), .pix_ce(s_pix_ce), .D(s_d),
    .hpos(s_hpos), .vpos(s_vpos), .hblank(s_hblank), .vblank(s_vblank),
    .red(s_red), .green(s_green), .blue(s_blue),
    .hsync_b(s_hsync_b), .vsync_b(s_vsync_b), .de(s_de), .frame_start(s_frame_start)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       de, hs_b, vs_b;
    int         h, v;
  } exp_t;

  exp_t q[$];
  int   mh, mv;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model_px(input logic [15:0] dw, input int h, input int v);
    exp_t e;
    int   i1;
    bit   blank;
    blank  = (h >= HV) || (v >= VV);
    i1     = int'(dw[15:12]) + 1;
    e.r    = blank ? 8'd0 : 8'(int'(dw[11:8]) * i1);
    e.g    = blank ? 8'd0 : 8'(int'(dw[7:4]) * i1);
    e.b    = blank ? 8'd0 : 8'(int'(dw[3:0]) * i1);
    e.de   = !blank;
    e.hs_b = !((h >= HSS) && (h < HSS + HSL));
    e.vs_b = !((v >= VSS) && (v < VSS + VSL));
    e.h    = h;
    e.v    = v;
    return e;
  endfunction

  // One pixel strobe on the default instance, followed by gap idle clocks
  task automatic strobe(input logic [15:0] dw, input int gap,
                        output exp_t got_e, output bit popped);
    exp_t       e;
    logic [7:0] hr, hg, hb;
    logic       hde, hhs, hvs;
    logic [8:0] hh;
    popped = 1'b0;
    got_e  = model_px(16'h0, 0, 0);
    d = dw;
    q.push_back(model_px(dw, mh, mv));
    checks++;
    if (hpos !== 9'(mh) || vpos !== 9'(mv)) begin
      errors++;
      $display("FAIL pos: hpos=%0d vpos=%0d expected %0d %0d", hpos, vpos, mh, mv);
    end
    checks++;
    if (hblank !== (mh >= HV) || vblank !== (mv >= VV)) begin
      errors++;
      $display("FAIL blank_raw at %0d,%0d: hblank=%b vblank=%b", mh, mv, hblank, vblank);
    end
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    if (q.size() >= 2) begin
      e      = q.pop_front();
      popped = 1'b1;
      got_e  = e;
      checks++;
      if ({red, green, blue, de, hsync_b, vsync_b} !== {e.r, e.g, e.b, e.de, e.hs_b, e.vs_b}) begin
        errors++;
        $display("FAIL pixel h=%0d v=%0d: got rgb=%0d,%0d,%0d de=%b hs=%b vs=%b expected rgb=%0d,%0d,%0d de=%b hs=%b vs=%b",
                 e.h, e.v, red, green, blue, de, hsync_b, vsync_b, e.r, e.g, e.b, e.de, e.hs_b, e.vs_b);
      end
    end
    hr = red; hg = green; hb = blue; hde = de; hhs = hsync_b; hvs = vsync_b; hh = hpos;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({red, green, blue, de, hsync_b, vsync_b, hpos} !== {hr, hg, hb, hde, hhs, hvs, hh}) begin
        errors++;
        $display("FAIL hold: got rgb=%0d,%0d,%0d de=%b hpos=%0d expected rgb=%0d,%0d,%0d de=%b hpos=%0d",
                 red, green, blue, de, hpos, hr, hg, hb, hde, hh);
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; pix_ce = 1'b0; d = 16'hFFFF;
    repeat (2) @(posedge clk);
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hpos, vpos} !== 18'd0 || {red, green, blue} !== 24'd0 || de !== 1'b0 ||
        hsync_b !== 1'b1 || vsync_b !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: hpos=%0d vpos=%0d rgb=%0d,%0d,%0d de=%b hs=%b vs=%b fs=%b expected zeros, syncs 1",
               hpos, vpos, red, green, blue, de, hsync_b, vsync_b, frame_start);
    end
    pix_ce = 1'b0;
    rst_b  = 1'b1;
    mh = 0; mv = 0;
    q.delete();
  endtask

  task automatic test_colours();
    logic [15:0] dws[4] = '{16'hFFFF, 16'h0841, 16'h7A0F, 16'h0000};
    logic [23:0] rgb[4] = '{{8'd240, 8'd240, 8'd240}, {8'd8, 8'd4, 8'd1},
                            {8'd80, 8'd0, 8'd120}, {8'd0, 8'd0, 8'd0}};
    exp_t e;
    bit   p;
    for (int i = 0; i < 5; i++) begin
      strobe((i < 4) ? dws[i] : 16'h1234, 0, e, p);
      if (i >= 1) begin
        checks++;
        if ({red, green, blue} !== rgb[i-1] || de !== 1'b1) begin
          errors++;
          $display("FAIL colour_%0d: got rgb=%0d,%0d,%0d de=%b expected %h de=1",
                   i - 1, red, green, blue, de, rgb[i-1]);
        end
      end
    end
    for (int i = 0; i < 12; i++) strobe(16'($urandom), 0, e, p);
  endtask

  task automatic test_hblank();
    exp_t e;
    bit   p, prev_hs, fall_seen;
    int   low_cnt;
    prev_hs = hsync_b; fall_seen = 1'b0; low_cnt = 0;
    while (!(mv == 1 && mh == 8)) begin
      strobe(16'hFFFF, 0, e, p);
      if (p) begin
        if (e.v == 0 && e.h >= HV) begin
          checks++;
          if ({red, green, blue} !== 24'd0 || de !== 1'b0) begin
            errors++;
            $display("FAIL hblank_out h=%0d: got rgb=%0d,%0d,%0d de=%b expected 0", e.h, red, green, blue, de);
          end
        end
        if (e.v == 0 && hsync_b === 1'b0) low_cnt++;
        if (prev_hs === 1'b1 && hsync_b === 1'b0) begin
          fall_seen = 1'b1;
          checks++;
          if (e.h != HSS) begin
            errors++;
            $display("FAIL hsync_fall: fell at delayed h=%0d expected %0d", e.h, HSS);
          end
        end
        prev_hs = hsync_b;
      end
    end
    checks++;
    if (!fall_seen || low_cnt != HSL) begin
      errors++;
      $display("FAIL hsync_len: fall_seen=%b low=%0d expected 1 and %0d", fall_seen, low_cnt, HSL);
    end
  endtask

  task automatic test_quarter_ce();
    exp_t e;
    bit   p;
    for (int i = 0; i < 24; i++) strobe(16'($urandom), 3, e, p);
  endtask

  task automatic test_frame_small();
    int first_k, last_k, pulses, hs_low, vs_low;
    first_k = -1; last_k = -1; pulses = 0; hs_low = 0; vs_low = 0;
    s_rst_b = 1'b0; s_pix_ce = 1'b0; s_d = 16'hFFFF;
    @(posedge clk); #1;
    s_rst_b = 1'b1; s_pix_ce = 1'b1;
    for (int k = 1; k <= 3 * SF; k++) begin
      @(posedge clk); #1;
      if (s_frame_start === 1'b1) begin
        pulses++;
        checks++;
        if ((last_k < 0 && k != SF) || (last_k >= 0 && k - last_k != SF)) begin
          errors++;
          $display("FAIL frame_interval: pulse at strobe %0d (prev %0d) expected period %0d", k, last_k, SF);
        end
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (k > SF && k <= 2 * SF) begin
        if (s_hsync_b === 1'b0) hs_low++;
        if (s_vsync_b === 1'b0) vs_low++;
      end
    end
    s_pix_ce = 1'b0;
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL frame_pulses: got %0d expected 3", pulses);
    end
    checks++;
    if (hs_low != SHSL * SVT) begin
      errors++;
      $display("FAIL hsync_frame: low strobes %0d expected %0d", hs_low, SHSL * SVT);
    end
    checks++;
    if (vs_low != SVSL * SHT) begin
      errors++;
      $display("FAIL vsync_frame: low strobes %0d expected %0d (%0d lines)", vs_low, SVSL * SHT, SVSL);
    end
  endtask

  task automatic test_reset_mid();
    s_rst_b = 1'b0; s_pix_ce = 1'b0; s_d = 16'hFFFF;
    @(posedge clk); #1;
    s_rst_b = 1'b1; s_pix_ce = 1'b1;
    repeat (5 * SHT + 10) @(posedge clk);
    #1;
    checks++;
    if (s_hpos !== 9'd10 || s_vpos !== 9'd5 || s_red !== 8'd240 || s_de !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: hpos=%0d vpos=%0d red=%0d de=%b expected 10 5 240 1", s_hpos, s_vpos, s_red, s_de);
    end
    #2;
    s_rst_b = 1'b0;
    #1;
    checks++;
    if ({s_hpos, s_vpos} !== 18'd0 || {s_red, s_green, s_blue} !== 24'd0 || s_de !== 1'b0 ||
        s_hsync_b !== 1'b1 || s_vsync_b !== 1'b1 || s_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: hpos=%0d vpos=%0d red=%0d de=%b hs=%b vs=%b expected reset values",
               s_hpos, s_vpos, s_red, s_de, s_hsync_b, s_vsync_b);
    end
    @(posedge clk); #1;
    s_pix_ce = 1'b0;
    s_rst_b  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_hpos !== 9'd0 || s_vpos !== 9'd0) begin
      errors++;
      $display("FAIL idle_after_reset: hpos=%0d vpos=%0d expected 0 0", s_hpos, s_vpos);
    end
    s_pix_ce = 1'b1;
    @(posedge clk); #1;
    s_pix_ce = 1'b0;
    checks++;
    if (s_hpos !== 9'd1 || s_vpos !== 9'd0) begin
      errors++;
      $display("FAIL restart: hpos=%0d vpos=%0d expected 1 0", s_hpos, s_vpos);
    end
  endtask

  initial begin
    rst_b = 1'b0; pix_ce = 1'b0; d = '0;
    s_rst_b = 1'b0; s_pix_ce = 1'b0; s_d = '0;
    mh = 0; mv = 0;
    test_reset();
    test_colours();
    test_hblank();
    test_quarter_ce();
    test_frame_small();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
